// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant.
// An optional hold limit forces rotation when other requesters are waiting.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16,
  parameter int TMR_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam int LIM_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [TMR_W-1:0] LIM = TMR_W'(LIM_I);
  localparam bit HAS_LIM = (MAX_HOLD != 0);

  state_e           state_q;
  logic [3:0]       gnt_q;
  logic [1:0]       id_q;
  logic             vld_q;
  logic [1:0]       last_q;
  logic [TMR_W-1:0] tmr_q;

  logic [1:0] base;
  logic [3:0] cand;
  logic [1:0] pick_id;
  logic       pick_ok;
  logic [3:0] pick_oh_d;
  logic       hreq;
  logic       at_lim;

  // Search starts after the holder while granted, after last otherwise.
  // The holder is masked so only other requesters count as candidates.
  always_comb begin
    base    = (state_q == GRANT) ? id_q : last_q;
    cand    = req & ~gnt_q;
    pick_ok = 1'b0;
    pick_id = base;
    for (int i = 1; i <= 4; i++) begin
      if (!pick_ok && cand[base + i[1:0]]) begin
        pick_ok = 1'b1;
        pick_id = base + i[1:0];
      end
    end
  end

  assign pick_oh_d = 4'b0001 << pick_id;
  assign hreq      = |(req & gnt_q);
  assign at_lim    = HAS_LIM && (tmr_q == LIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      id_q    <= 2'd0;
      vld_q   <= 1'b0;
      last_q  <= 2'd3;
      tmr_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en && pick_ok) begin
            state_q <= GRANT;
            gnt_q   <= pick_oh_d;
            id_q    <= pick_id;
            vld_q   <= 1'b1;
            tmr_q   <= '0;
          end
        end
        GRANT: begin
          if (!hreq) begin
            last_q <= id_q;
            tmr_q  <= '0;
            if (en && pick_ok) begin
              gnt_q <= pick_oh_d;
              id_q  <= pick_id;
            end else begin
              state_q <= IDLE;
              gnt_q   <= 4'b0000;
              id_q    <= 2'd0;
              vld_q   <= 1'b0;
            end
          end else if (at_lim && en && pick_ok) begin
            last_q <= id_q;
            gnt_q  <= pick_oh_d;
            id_q   <= pick_id;
            tmr_q  <= '0;
          end else if (tmr_q != LIM) begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = vld_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: two hold limits, directed cases and random traffic.
// A queue-free reference model tracks holder, pointer and hold count.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] id_a, id_b;
  logic       vld_a, vld_b;

  int checks   = 0;
  int failures = 0;

  int mh[2] = '{2, 4};
  int mg[2];
  int ml[2];
  int mt[2];

  rr_arbiter4 #(.MAX_HOLD(2), .TMR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(vld_a)
  );

  rr_arbiter4 #(.MAX_HOLD(4), .TMR_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt_b), .gnt_id(id_b), .gnt_valid(vld_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int from, input logic [3:0] r,
                              input int excl);
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (from + i) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model(input int k);
    logic [3:0] oth;
    int h;
    if (!rst_n) begin
      mg[k] = -1; ml[k] = 3; mt[k] = 0;
    end else if (mg[k] < 0) begin
      if (en && req != 4'b0) begin
        mg[k] = pick(ml[k], req, -1);
        mt[k] = 0;
      end
    end else begin
      h   = mg[k];
      oth = req & ~(4'(1) << h);
      if (!req[h]) begin
        ml[k] = h;
        mg[k] = (en && oth != 0) ? pick(h, req, h) : -1;
        mt[k] = 0;
      end else if (mh[k] != 0 && mt[k] == mh[k] - 1 && en && oth != 0) begin
        ml[k] = h;
        mg[k] = pick(h, req, h);
        mt[k] = 0;
      end else if (mt[k] < mh[k] - 1) begin
        mt[k]++;
      end
    end
  endtask

  function automatic int exp_gnt(input int k);
    return (mg[k] < 0) ? 0 : (1 << mg[k]);
  endfunction

  function automatic int exp_id(input int k);
    return (mg[k] < 0) ? 0 : mg[k];
  endfunction

  // One clock: advance the model on the edge, then compare just after it.
  task automatic cyc();
    @(posedge clk);
    model(0);
    model(1);
    #1;
    chk("a_gnt", int'(gnt_a), exp_gnt(0));
    chk("a_id",  int'(id_a),  exp_id(0));
    chk("a_vld", int'(vld_a), int'(mg[0] >= 0));
    chk("b_gnt", int'(gnt_b), exp_gnt(1));
    chk("b_id",  int'(id_b),  exp_id(1));
    chk("b_vld", int'(vld_b), int'(mg[1] >= 0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  int rr_seq[9] = '{1, 1, 2, 2, 4, 4, 8, 8, 1};
  int rr_id[9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0;
    for (int k = 0; k < 2; k++) begin
      mg[k] = -1; ml[k] = 3; mt[k] = 0;
    end
    cyc();
    cyc();
    chk("rst_gnt", int'(gnt_a), 0);
    chk("rst_vld", int'(vld_a), 0);
    rst_n = 1'b1;

    // Single requester, then release.
    en = 1'b1; req = 4'b0001;
    cyc();
    chk("one_gnt", int'(gnt_a), 1);
    chk("one_id",  int'(id_a),  0);
    chk("one_vld", int'(vld_a), 1);
    req = 4'b0000;
    cyc();
    chk("drop_gnt", int'(gnt_a), 0);

    // Full contention with hold limit 2.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("rr_gnt", int'(gnt_a), rr_seq[i]);
      chk("rr_id",  int'(id_a),  rr_id[i]);
    end

    // Back-to-back handover searching from holder 1.
    do_reset();
    req = 4'b0010;
    cyc();
    req = 4'b1001;
    cyc();
    chk("hand_gnt", int'(gnt_a), 8);
    chk("hand_id",  int'(id_a),  3);

    // Enable gating of new grants.
    do_reset();
    en = 1'b0; req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("en0_gnt", int'(gnt_a), 0);
    end
    en = 1'b1;
    cyc();
    chk("en1_gnt", int'(gnt_a), 4);

    // Holder survives en=0, then drains to idle.
    do_reset();
    en = 1'b1; req = 4'b0001;
    cyc();
    en = 1'b0; req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("keep_gnt", int'(gnt_a), 1);
    end
    req = 4'b1110;
    cyc();
    chk("drain_gnt", int'(gnt_a), 0);
    cyc();
    chk("drain_vld", int'(vld_a), 0);

    // Uncontended hold beyond the limit, then preemption.
    do_reset();
    en = 1'b1; req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("unc_gnt", int'(gnt_b), 2);
    end
    req = 4'b1010;
    cyc();
    chk("pre_gnt", int'(gnt_b), 8);
    chk("pre_id",  int'(id_b),  3);

    // Reset in the middle of a grant.
    do_reset();
    req = 4'b0100;
    cyc();
    chk("mid_pre", int'(gnt_a), 4);
    rst_n = 1'b0;
    cyc();
    chk("mid_gnt", int'(gnt_a), 0);
    chk("mid_id",  int'(id_a),  0);
    chk("mid_vld", int'(vld_a), 0);
    rst_n = 1'b1; req = 4'b1111;
    cyc();
    chk("mid_first", int'(gnt_a), 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      else if ($urandom_range(0, 1) == 0) req = req ^ (4'(1) << $urandom_range(0, 3));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource between four agents.
- Produces a one-hot grant plus the 2-bit encoded grant index, in the same encoding as the 4x2 encoder: requester k maps to binary k.
- Holds a grant while its requester keeps req asserted, with an optional hold limit that forces rotation under contention.
- Sits between the request sources and the shared datapath's select/mux control.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles for one holder while others wait; 0 = unlimited; legal range 0..255
TMR_W, 8, width of internal hold timer; must satisfy 2**TMR_W > MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
en  input  1  arbitration enable; gates new grants only
req  input  4  request vector, bit k = requester k, level-sensitive
gnt  output  4  one-hot registered grant, all-zero when idle
gnt_id  output  2  binary index of current holder (encoder mapping: 0001->00, 0010->01, 0100->10, 1000->11); 00 when idle
gnt_valid  output  1  high iff gnt != 0

Behaviour:
- Reset is synchronous (rst_n sampled low at a rising clk edge):
  - gnt=0000, gnt_id=00, gnt_valid=0, state=IDLE, timer=0.
  - Last-served pointer last=3, so requester 0 has first priority after reset.
  - Reset asserted mid-grant drops the grant on that same edge; no release bookkeeping.
- All outputs are registered. gnt, gnt_id and gnt_valid always change on the same edge and are mutually consistent.
- Round-robin pick: search order is last+1, last+2, last+3, last (mod 4); the first asserted candidate wins.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0: the pick is granted on the next edge (1-cycle latency from req sampled to gnt); go to GRANT; timer=0.
  - Otherwise stay in IDLE.
- GRANT, holder h:
  - Release (req[h]=0 sampled): last<=h. If en=1 and any other req is set, the next pick (search from h+1) is granted on this same edge, giving back-to-back handover with no idle cycle. Otherwise gnt<=0000, go to IDLE.
  - Preempt (MAX_HOLD!=0, timer==MAX_HOLD-1, req[h]=1, en=1, and some other req set): last<=h; grant moves to the pick from h+1 on this edge; timer<=0.
  - Hold (otherwise): holder kept. timer increments, saturating at MAX_HOLD-1. When the holder is uncontended at the limit, it keeps the grant; preemption fires the first cycle another request appears.
  - Any grant change resets timer to 0.
- en=0:
  - No new grant is issued and no preemption occurs.
  - The current holder keeps the grant until it releases, then the arbiter drains to IDLE.
  - en is re-sampled every cycle.
- Simultaneous release and new requests: arbitration uses the req vector sampled on that edge, excluding h.
- Requests are not latched. A req pulse that drops before being granted is lost.
- A grant is never given to a requester whose req is low at the deciding edge.
- Wrap-around: the pointer wraps 3->0. last is updated only on release or preempt, never in IDLE.
- Fairness: under continuous contention with MAX_HOLD=N, each active requester waits at most 3*N cycles.

Test Plan:
- Reset then req=0001, en=1: gnt=0001, gnt_id=00, gnt_valid=1 one cycle later. Drop req: gnt=0000 next edge.
- Round robin: all req=1111, MAX_HOLD=2, en=1. Expected grant sequence: 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001 … with gnt_id 00, 00, 01, 01, 10, 10, 11, 11, 00.
- Back-to-back handover: holder 1 (req=0010) drops req while req=1001. Next edge gives gnt=1000, gnt_id=11 (search from 2), with no idle cycle.
- Enable gating:
  - en=0, req=0100: gnt stays 0000 for 5 cycles. Raising en gives gnt=0100 one edge later.
  - en dropped while holder 0 active: holder retained until its release, then gnt=0000 even with req=1110.
- Uncontended hold: MAX_HOLD=4, req=0010 only for 20 cycles: gnt=0010 throughout. Raising req[3] at cycle 20 yields gnt=1000 on the following edge.
- Reset mid-grant: rst_n=0 while gnt=0100. Outputs read 0000/00/0 after that edge. After rst_n=1 with req=1111, first grant is 0001.
